// File: rtl/result_serializer_pkg.sv
// Shared matrix-stage definitions: serializer state encoding and index-width helper.
package result_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } mat_state_t;

    // Row/column index width for an N x N matrix, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_serializer.sv
// Captures N rows of a result matrix, then streams its elements row-major over valid/ready.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  row_valid_in,
    input  logic signed [2*DATAWIDTH-1:0]         row_in [N_SIZE],
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic signed [2*DATAWIDTH-1:0]         out_data,
    output logic [idx_width(N_SIZE)-1:0]          out_row,
    output logic [idx_width(N_SIZE)-1:0]          out_col,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  overflow_err
);

    localparam int unsigned EW    = 2 * DATAWIDTH;
    localparam int unsigned IDX_W = idx_width(N_SIZE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SIZE - 1);

    mat_state_t               r_state;
    logic [IDX_W-1:0]         r_row_cnt;
    logic signed [EW-1:0]     r_buf [N_SIZE][N_SIZE];
    logic                     r_out_valid;
    logic signed [EW-1:0]     r_out_data;
    logic [IDX_W-1:0]         r_out_row;
    logic [IDX_W-1:0]         r_out_col;
    logic                     r_out_last;
    logic                     r_overflow;

    logic                     w_wr;
    logic [IDX_W-1:0]         w_wr_row;
    logic signed [EW-1:0]     w_first;
    logic [IDX_W-1:0]         w_nxt_row;
    logic [IDX_W-1:0]         w_nxt_col;

    always_comb begin
        w_wr      = row_valid_in && (r_state != ST_DRAIN);
        w_wr_row  = (r_state == ST_IDLE) ? '0 : r_row_cnt;
        // A single-row matrix drains straight from the row being written.
        w_first   = (w_wr_row == '0) ? row_in[0] : r_buf[0][0];
        w_nxt_row = r_out_row;
        w_nxt_col = r_out_col + IDX_W'(1);
        if (r_out_col == LAST) begin
            w_nxt_col = '0;
            w_nxt_row = r_out_row + IDX_W'(1);
        end
    end

    // Buffer is not reset; it is only read after a full capture.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int c = 0; c < N_SIZE; c++) begin
                r_buf[w_wr_row][c] <= row_in[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_row_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_CAPTURE: begin
                    if (w_wr) begin
                        if (w_wr_row == LAST) begin
                            r_state     <= ST_DRAIN;
                            r_row_cnt   <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_first;
                            r_out_row   <= '0;
                            r_out_col   <= '0;
                            r_out_last  <= 1'(N_SIZE == 1);
                        end else begin
                            r_state   <= ST_CAPTURE;
                            r_row_cnt <= w_wr_row + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (row_valid_in) begin
                        r_overflow <= 1'b1;
                    end
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_row   <= '0;
                            r_out_col   <= '0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_out_row  <= w_nxt_row;
                            r_out_col  <= w_nxt_col;
                            r_out_data <= r_buf[w_nxt_row][w_nxt_col];
                            r_out_last <= (w_nxt_row == LAST) && (w_nxt_col == LAST);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign out_last     = r_out_last;
    assign busy         = (r_state != ST_IDLE);
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer at N=3, DATAWIDTH=16.
module tb_result_serializer;

    localparam int DW = 16;
    localparam int N  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               row_valid_in = 1'b0;
    logic signed [31:0] row_in [N];
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic [1:0]         out_row;
    logic [1:0]         out_col;
    logic               out_last;
    logic               busy;
    logic               overflow_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_a [9];
    logic [31:0] m_n [9];
    logic [31:0] m_b [9];

    result_serializer #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .row_valid_in (row_valid_in),
        .row_in       (row_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_row"},   32'(out_row),   32'd0);
        chk({tag, "_col"},   32'(out_col),   32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    task automatic load(input logic [31:0] m [9], input int gap);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) row_in[c] = m[r*N + c];
            row_valid_in = 1'b1;
            step();
            row_valid_in = 1'b0;
            if (r < N - 1) begin
                chk("capture_busy", 32'(busy), 32'd1);
                chk("capture_novalid", 32'(out_valid), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk("gap_novalid", 32'(out_valid), 32'd0);
                end
            end
        end
        for (int c = 0; c < N; c++) row_in[c] = 32'hDEAD_BEEF;
    endtask

    // Drain with optional ready toggling (ready=0 on even cycles) and row pulses per cycle mask.
    task automatic drain(input logic [31:0] m [9], input bit tog, input logic [31:0] pulse,
                         input int exp_cycles);
        int  idx = 0;
        int  cyc = 0;
        bit  rdy;
        while (idx < 9 && cyc < 100) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data",  32'(out_data),  m[idx]);
            chk("drain_row",   32'(out_row),   32'(idx / N));
            chk("drain_col",   32'(out_col),   32'(idx % N));
            chk("drain_last",  32'(out_last),  32'(idx == 8));
            chk("drain_busy",  32'(busy),      32'd1);
            rdy = tog ? cyc[0] : 1'b1;
            out_ready    = rdy;
            row_valid_in = pulse[cyc % 32];
            step();
            if (rdy) idx++;
            cyc++;
        end
        row_valid_in = 1'b0;
        out_ready    = 1'b0;
        chk("drain_cycles", 32'(cyc), 32'(exp_cycles));
        chk("after_valid", 32'(out_valid), 32'd0);
        chk("after_busy",  32'(busy),      32'd0);
        chk("after_last",  32'(out_last),  32'd0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            m_a[i] = 32'(i + 1);
            m_n[i] = 32'(i + 1);
            m_b[i] = 32'(i + 10);
        end
        m_n[3] = 32'hC000_8000;
        m_n[4] = 32'hFFFF_FFFF;
        m_n[5] = 32'h8000_0000;
        for (int c = 0; c < N; c++) row_in[c] = '0;

        rst = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset_ovf", 32'(overflow_err), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk_idle("post_reset");

        // Back-to-back rows, ready always high.
        load(m_a, 0);
        drain(m_a, 1'b0, 32'd0, 9);

        // Ready toggling; each element held for the ready-low cycle.
        load(m_a, 0);
        drain(m_a, 1'b1, 32'd0, 18);

        // Two idle cycles between rows.
        load(m_a, 2);
        drain(m_a, 1'b0, 32'd0, 9);

        // Signed extremes in the second row.
        load(m_n, 0);
        drain(m_n, 1'b0, 32'd0, 9);
        chk("neg_ovf_clear", 32'(overflow_err), 32'd0);

        // Rows arriving mid-drain and on the final handshake are dropped.
        load(m_a, 0);
        drain(m_a, 1'b0, 32'h0000_0104, 9);
        chk("ovf_set", 32'(overflow_err), 32'd1);
        step();
        step();
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        chk("ovf_idle_busy", 32'(busy), 32'd0);
        chk("ovf_idle_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a drain, then a fresh matrix.
        load(m_b, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("mid_data", 32'(out_data), m_b[4]);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_ovf", 32'(overflow_err), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk_idle("mid_rst_hold");
        load(m_b, 1);
        drain(m_b, 1'b0, 32'd0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
